// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and constants for the counter-game controller.
//                Holds the controller state enum, the counter mode encodings
//                (also imported by the counter) and the run result codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // Counter count-mode encodings (ctrl)
    localparam logic [1:0] UP_ONE   = 2'b00;
    localparam logic [1:0] UP_TWO   = 2'b01;
    localparam logic [1:0] DOWN_ONE = 2'b10;
    localparam logic [1:0] DOWN_TWO = 2'b11;

    // Run outcome codes; LOSER/WINNER match the counter's WHO encoding
    localparam logic [1:0] RES_ABORT   = 2'b00;
    localparam logic [1:0] RES_LOSER   = 2'b01;
    localparam logic [1:0] RES_WINNER  = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/game_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_controller_if
//  Description : Command/report interface between the sequencer (master) and
//                the game controller (slave).
//                master drives : cmd_valid, cmd_mode, cmd_load, cmd_cycles,
//                                abort
//                slave drives  : cmd_ready, busy, done, result, lose_events,
//                                win_events
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_controller_if #(
    parameter int COUNTER_SIZE = 4,
    parameter int RUN_W        = 8,
    parameter int EVT_W        = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_mode;
    logic [COUNTER_SIZE-1:0] cmd_load;
    logic [RUN_W-1:0]        cmd_cycles;
    logic                    abort;
    logic                    busy;
    logic                    done;
    logic [1:0]              result;
    logic [EVT_W-1:0]        lose_events;
    logic [EVT_W-1:0]        win_events;

    modport master (
        output cmd_valid, cmd_mode, cmd_load, cmd_cycles, abort,
        input  cmd_ready, busy, done, result, lose_events, win_events
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_load, cmd_cycles, abort,
        output cmd_ready, busy, done, result, lose_events, win_events
    );
endinterface
`default_nettype wire

// File: rtl/game_controller_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : EVT_W-bit event counter that sticks at all-ones.
//                clk     in  clock
//                rst_l   in  asynchronous active-low reset
//                i_clr   in  synchronous clear (wins over i_inc)
//                i_inc   in  count one event
//                o_count out current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int EVT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_l,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic      [EVT_W-1:0] o_count
);
    logic [EVT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {EVT_W{1'b1}})) begin
            r_count <= r_count + EVT_W'(1);
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : game_controller
//  Description : Command-driven driver for the multi-mode counter game.
//                Parks the counter, loads a start value, runs it in the
//                requested mode for cmd_cycles cycles (0 = until GAMEOVER),
//                counts LOSER/WINNER pulses and reports the outcome.
//                clk        in  clock shared with the counter
//                rst_l      in  asynchronous active-low reset
//                cmd        if  command/report interface (slave side)
//                ctrl       out counter count mode
//                INIT       out counter load/park strobe
//                loadValue  out counter start value
//                LOSER, WINNER, GAMEOVER, WHO  in  counter status
//  Revision    : 1.0 - initial release
// ============================================================================
module game_controller
    import game_pkg::*;
#(
    parameter int COUNTER_SIZE = 4,
    parameter int RUN_W        = 8,
    parameter int EVT_W        = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst_l,
    game_controller_if.slave             cmd,
    output logic      [1:0]              ctrl,
    output logic                         INIT,
    output logic      [COUNTER_SIZE-1:0] loadValue,
    input  wire logic                    LOSER,
    input  wire logic                    WINNER,
    input  wire logic                    GAMEOVER,
    input  wire logic [1:0]              WHO
);
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_result;
    logic [1:0]              w_result_nxt;
    logic [RUN_W-1:0]        r_cycles;
    logic [RUN_W-1:0]        r_run_cnt;
    logic [1:0]              r_ctrl;
    logic [COUNTER_SIZE-1:0] r_load;
    logic                    r_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_init;
    logic                    w_accept;
    logic                    w_run_last;
    logic                    w_in_run;

    assign w_accept = cmd.cmd_valid && r_ready;
    assign w_in_run = (r_state == ST_RUN);

    // The count reaches r_cycles on this edge; r_run_cnt holds completed
    // RUN edges, so the exit edge is the one where it would become r_cycles.
    assign w_run_last = (r_cycles != '0) && ((r_run_cnt + RUN_W'(1)) == r_cycles);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and next result
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_LOAD;
                    w_result_nxt = RES_ABORT;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // abort > GAMEOVER > cycle expiry
                if (cmd.abort) begin
                    w_state_nxt  = ST_REPORT;
                    w_result_nxt = RES_ABORT;
                end else if (GAMEOVER) begin
                    // WHO is only valid alongside GAMEOVER
                    w_state_nxt  = ST_REPORT;
                    w_result_nxt = WHO;
                end else if (w_run_last) begin
                    w_state_nxt  = ST_REPORT;
                    w_result_nxt = RES_TIMEOUT;
                end
            end
            ST_REPORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the next state so they line up
    // with the state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_init    <= 1'b1;
            r_result  <= RES_ABORT;
            r_ctrl    <= UP_ONE;
            r_load    <= '0;
            r_cycles  <= '0;
            r_run_cnt <= '0;
        end else begin
            r_ready  <= (w_state_nxt == ST_IDLE);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= (w_state_nxt == ST_REPORT);
            r_init   <= (w_state_nxt != ST_RUN);
            r_result <= w_result_nxt;
            if (w_accept) begin
                r_ctrl    <= cmd.cmd_mode;
                r_load    <= cmd.cmd_load;
                r_cycles  <= cmd.cmd_cycles;
                r_run_cnt <= '0;
            end else if (w_in_run) begin
                r_run_cnt <= r_run_cnt + RUN_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-run event totals
    // ------------------------------------------------------------------
    sat_counter #(.EVT_W(EVT_W)) u_lose_cnt (
        .clk     (clk),
        .rst_l   (rst_l),
        .i_clr   (w_accept),
        .i_inc   (w_in_run && LOSER),
        .o_count (cmd.lose_events)
    );

    sat_counter #(.EVT_W(EVT_W)) u_win_cnt (
        .clk     (clk),
        .rst_l   (rst_l),
        .i_clr   (w_accept),
        .i_inc   (w_in_run && WINNER),
        .o_count (cmd.win_events)
    );

    assign cmd.cmd_ready = r_ready;
    assign cmd.busy      = r_busy;
    assign cmd.done      = r_done;
    assign cmd.result    = r_result;
    assign ctrl          = r_ctrl;
    assign INIT          = r_init;
    assign loadValue     = r_load;
endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_controller
//  Description : Directed self-checking bench for game_controller. The
//                counter is replaced by directly driven LOSER/WINNER/
//                GAMEOVER/WHO pulses placed in the RUN sampling window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_controller;
    localparam int COUNTER_SIZE = 4;
    localparam int RUN_W        = 8;
    localparam int EVT_W        = 8;

    logic                    clk;
    logic                    rst_l;
    logic [1:0]              ctrl;
    logic                    INIT;
    logic [COUNTER_SIZE-1:0] loadValue;
    logic                    LOSER;
    logic                    WINNER;
    logic                    GAMEOVER;
    logic [1:0]              WHO;

    int n_checks = 0;
    int n_fail   = 0;

    game_controller_if #(
        .COUNTER_SIZE (COUNTER_SIZE),
        .RUN_W        (RUN_W),
        .EVT_W        (EVT_W)
    ) cmd_if ();

    game_controller #(
        .COUNTER_SIZE (COUNTER_SIZE),
        .RUN_W        (RUN_W),
        .EVT_W        (EVT_W)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .cmd       (cmd_if),
        .ctrl      (ctrl),
        .INIT      (INIT),
        .loadValue (loadValue),
        .LOSER     (LOSER),
        .WINNER    (WINNER),
        .GAMEOVER  (GAMEOVER),
        .WHO       (WHO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present counter status for one edge, then clear it
    task automatic step(input logic l, input logic w, input logic g,
                        input logic [1:0] who, input logic ab);
        LOSER         = l;
        WINNER        = w;
        GAMEOVER      = g;
        WHO           = who;
        cmd_if.abort  = ab;
        @(posedge clk); #1;
        LOSER         = 1'b0;
        WINNER        = 1'b0;
        GAMEOVER      = 1'b0;
        WHO           = 2'b00;
        cmd_if.abort  = 1'b0;
    endtask

    // Offer a command for one edge (the accept edge E0)
    task automatic issue(input logic [1:0] mode, input logic [3:0] load, input logic [7:0] cyc);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_mode   = mode;
        cmd_if.cmd_load   = load;
        cmd_if.cmd_cycles = cyc;
        @(posedge clk); #1;
        cmd_if.cmd_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l             = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_mode   = 2'b00;
        cmd_if.cmd_load   = '0;
        cmd_if.cmd_cycles = '0;
        cmd_if.abort      = 1'b0;
        LOSER             = 1'b0;
        WINNER            = 1'b0;
        GAMEOVER          = 1'b0;
        WHO               = 2'b00;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready",  cmd_if.cmd_ready,   1);
        check_val("rst_busy",   cmd_if.busy,        0);
        check_val("rst_done",   cmd_if.done,        0);
        check_val("rst_init",   INIT,               1);
        check_val("rst_ctrl",   ctrl,               0);
        check_val("rst_load",   loadValue,          0);
        check_val("rst_result", cmd_if.result,      0);
        check_val("rst_lose",   cmd_if.lose_events, 0);
        check_val("rst_win",    cmd_if.win_events,  0);
        rst_l = 1'b1;
        @(posedge clk); #1;

        // ---------------- load 14, up1, 4 cycles ----------------
        issue(2'b00, 4'd14, 8'd4);                          // E0
        check_val("t1_load_init",  INIT,             1);
        check_val("t1_loadvalue",  loadValue,        14);
        check_val("t1_ctrl",       ctrl,             0);
        check_val("t1_ready_lo",   cmd_if.cmd_ready, 0);
        check_val("t1_busy",       cmd_if.busy,      1);
        step(1, 0, 0, 2'b00, 0);                            // E1: LOSER in LOAD ignored
        check_val("t1_run_init",   INIT,               0);
        check_val("t1_lose_load",  cmd_if.lose_events, 0);
        step(0, 0, 0, 2'b00, 0);                            // E2
        step(1, 0, 0, 2'b00, 0);                            // E3
        check_val("t1_lose_mid",   cmd_if.lose_events, 1);
        step(0, 1, 0, 2'b00, 0);                            // E4
        check_val("t1_done_early", cmd_if.done,        0);
        step(0, 0, 0, 2'b00, 0);                            // E5: expiry
        check_val("t1_done",       cmd_if.done,        1);
        check_val("t1_result",     cmd_if.result,      3);
        check_val("t1_lose",       cmd_if.lose_events, 1);
        check_val("t1_win",        cmd_if.win_events,  1);
        check_val("t1_rep_init",   INIT,               1);
        check_val("t1_rep_ready",  cmd_if.cmd_ready,   0);
        step(1, 0, 0, 2'b00, 0);                            // E6: LOSER in REPORT ignored
        check_val("t1_done_once",  cmd_if.done,        0);
        check_val("t1_ready",      cmd_if.cmd_ready,   1);
        check_val("t1_res_hold",   cmd_if.result,      3);
        check_val("t1_lose_hold",  cmd_if.lose_events, 1);

        // ---------------- load 0, down1, until GAMEOVER (loser) ----------------
        issue(2'b10, 4'd0, 8'd0);
        check_val("t2_ctrl",       ctrl,               2);
        check_val("t2_res_clr",    cmd_if.result,      0);
        check_val("t2_lose_clr",   cmd_if.lose_events, 0);
        step(0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 2'b00, 0);
        check_val("t2_busy",       cmd_if.busy,        1);
        check_val("t2_no_done",    cmd_if.done,        0);
        step(0, 0, 1, 2'b01, 0);
        check_val("t2_done",       cmd_if.done,        1);
        check_val("t2_result",     cmd_if.result,      1);
        check_val("t2_lose",       cmd_if.lose_events, 15);
        check_val("t2_win",        cmd_if.win_events,  0);
        step(0, 0, 0, 2'b00, 0);

        // ---------------- load 13, up2, until GAMEOVER (winner) ----------------
        issue(2'b01, 4'd13, 8'd0);
        check_val("t3_ctrl",       ctrl,               1);
        step(0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 2'b00, 0);
        step(0, 0, 1, 2'b10, 0);
        check_val("t3_done",       cmd_if.done,        1);
        check_val("t3_result",     cmd_if.result,      2);
        check_val("t3_win",        cmd_if.win_events,  15);
        check_val("t3_lose",       cmd_if.lose_events, 0);
        step(0, 0, 0, 2'b00, 0);

        // ---------------- abort 3 cycles into RUN (beats GAMEOVER) ----------------
        issue(2'b00, 4'd5, 8'd0);
        step(0, 0, 0, 2'b00, 1);                            // abort in LOAD ignored
        check_val("t4_busy_load",  cmd_if.busy,        1);
        check_val("t4_init_run",   INIT,               0);
        step(0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);
        step(0, 0, 1, 2'b10, 1);
        check_val("t4_done",       cmd_if.done,        1);
        check_val("t4_result",     cmd_if.result,      0);
        step(0, 0, 0, 2'b00, 1);                            // abort in REPORT ignored
        check_val("t4_ready",      cmd_if.cmd_ready,   1);
        check_val("t4_done_off",   cmd_if.done,        0);

        // ---------------- event counter saturation ----------------
        issue(2'b00, 4'd0, 8'd0);
        step(0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 260; i++) step(1, 1, 0, 2'b00, 0);
        check_val("t5_lose_sat",   cmd_if.lose_events, 255);
        check_val("t5_win_sat",    cmd_if.win_events,  255);
        step(0, 0, 0, 2'b00, 1);
        check_val("t5_abort_res",  cmd_if.result,      0);
        step(0, 0, 0, 2'b00, 0);

        // ---------------- reset mid-RUN ----------------
        issue(2'b11, 4'd9, 8'd0);
        step(0, 0, 0, 2'b00, 0);
        step(1, 0, 0, 2'b00, 0);
        step(1, 0, 0, 2'b00, 0);
        check_val("t6_lose_pre",   cmd_if.lose_events, 2);
        rst_l = 1'b0;
        #2;
        check_val("t6_busy",       cmd_if.busy,        0);
        check_val("t6_ready",      cmd_if.cmd_ready,   1);
        check_val("t6_init",       INIT,               1);
        check_val("t6_load",       loadValue,          0);
        check_val("t6_ctrl",       ctrl,               0);
        check_val("t6_lose",       cmd_if.lose_events, 0);
        check_val("t6_done",       cmd_if.done,        0);
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk); #1;
        check_val("t6_no_done",    cmd_if.done,        0);
        issue(2'b11, 4'd7, 8'd2);
        check_val("t6_acc_busy",   cmd_if.busy,        1);
        check_val("t6_acc_load",   loadValue,          7);
        check_val("t6_acc_ctrl",   ctrl,               3);
        step(0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);
        check_val("t6_res",        cmd_if.result,      3);
        check_val("t6_done2",      cmd_if.done,        1);
        step(0, 0, 0, 2'b00, 0);

        // ---------------- GAMEOVER on final counted cycle, min spacing ----------------
        issue(2'b00, 4'd1, 8'd3);
        step(0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);
        check_val("t7_no_done",    cmd_if.done,        0);
        step(0, 0, 1, 2'b01, 0);
        check_val("t7_done",       cmd_if.done,        1);
        check_val("t7_result",     cmd_if.result,      1);
        step(0, 0, 0, 2'b00, 0);
        check_val("t7_ready",      cmd_if.cmd_ready,   1);
        issue(2'b10, 4'd4, 8'd1);
        check_val("t7_b2b_busy",   cmd_if.busy,        1);
        check_val("t7_b2b_load",   loadValue,          4);
        check_val("t7_b2b_res",    cmd_if.result,      0);
        step(0, 0, 0, 2'b00, 0);
        step(0, 0, 1, 2'b10, 0);
        check_val("t7_b2b_done",   cmd_if.done,        1);
        check_val("t7_b2b_result", cmd_if.result,      2);
        step(0, 0, 0, 2'b00, 0);
        issue(2'b00, 4'd3, 8'd1);
        check_val("t7_b3_load",    loadValue,          3);
        step(0, 0, 0, 2'b00, 0);
        step(0, 0, 0, 2'b00, 0);
        check_val("t7_b3_result",  cmd_if.result,      3);
        check_val("t7_b3_done",    cmd_if.done,        1);
        step(0, 0, 0, 2'b00, 0);
        check_val("t7_b3_ready",   cmd_if.cmd_ready,   1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
